// File: rtl/gpio_debounce_pkg.sv
// Shared types and constants for the GPIO input debounce block.
package gpio_debounce_pkg;

  localparam int unsigned GlitchCntWidth = 16;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    CHECK_HI  = 2'b01,
    STABLE_HI = 2'b10,
    CHECK_LO  = 2'b11
  } debounce_state_e;

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchronizer for a single asynchronous input bit.
module gpio_sync
  import gpio_debounce_pkg::*;
#(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [SyncStages-1:0] sync_q;

  // Shift the raw level through the flop chain; the oldest bit is the output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], d_i};
    end
  end

  assign q_o = sync_q[SyncStages-1];

endmodule

// File: rtl/gpio_debounce.sv
// GPIO input conditioning: synchronize, debounce against a stable-time window,
// emit a clean level with single-cycle edge strobes, count rejected glitches.
module gpio_debounce
  import gpio_debounce_pkg::*;
#(
  parameter int unsigned SyncStages = 2,
  parameter int unsigned StableCnt  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic                      clr_i,
  input  logic                      gpio_i,
  output logic                      gpio_o,
  output logic                      rise_o,
  output logic                      fall_o,
  output logic [GlitchCntWidth-1:0] glitch_cnt_o
);

  localparam int unsigned CntW = $clog2(StableCnt + 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntLast = CntW'(StableCnt - 1);

  logic                      s;
  debounce_state_e           state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      gpio_q, gpio_d;
  logic                      rise_q, rise_d;
  logic                      fall_q, fall_d;
  logic [GlitchCntWidth-1:0] glitch_cnt_q, glitch_cnt_d;
  logic                      glitch_inc;

  gpio_sync #(
    .SyncStages(SyncStages)
  ) u_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (gpio_i),
    .q_o  (s)
  );

  // Debounce FSM: a new level must be seen on StableCnt consecutive edges.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gpio_d     = gpio_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    glitch_inc = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        if (en_i && s) begin
          if (StableCnt == 1) begin
            state_d = STABLE_HI;
            gpio_d  = 1'b1;
            rise_d  = 1'b1;
          end else begin
            state_d = CHECK_HI;
            cnt_d   = CntOne;
          end
        end
      end
      CHECK_HI: begin
        if (!en_i) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (s) begin
          if (cnt_q == CntLast) begin
            state_d = STABLE_HI;
            gpio_d  = 1'b1;
            rise_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end else begin
          state_d    = STABLE_LO;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end
      end
      STABLE_HI: begin
        if (en_i && !s) begin
          if (StableCnt == 1) begin
            state_d = STABLE_LO;
            gpio_d  = 1'b0;
            fall_d  = 1'b1;
          end else begin
            state_d = CHECK_LO;
            cnt_d   = CntOne;
          end
        end
      end
      CHECK_LO: begin
        if (!en_i) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (!s) begin
          if (cnt_q == CntLast) begin
            state_d = STABLE_LO;
            gpio_d  = 1'b0;
            fall_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end else begin
          state_d    = STABLE_HI;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
        gpio_d  = 1'b0;
      end
    endcase
  end

  // Saturating glitch counter; a clear wins over a same-cycle increment.
  always_comb begin
    glitch_cnt_d = glitch_cnt_q;
    if (clr_i) begin
      glitch_cnt_d = '0;
    end else if (glitch_inc && (glitch_cnt_q != '1)) begin
      glitch_cnt_d = glitch_cnt_q + GlitchCntWidth'(1);
    end
  end

  // State, level, strobe and counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= STABLE_LO;
      cnt_q        <= '0;
      gpio_q       <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      glitch_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gpio_q       <= gpio_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign gpio_o       = gpio_q;
  assign rise_o       = rise_q;
  assign fall_o       = fall_q;
  assign glitch_cnt_o = glitch_cnt_q;

endmodule

// File: tb/tb_gpio_debounce.sv
// Directed bench for gpio_debounce with SyncStages=2, StableCnt=4.
module tb_gpio_debounce;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned StableCnt  = 4;

  typedef struct {
    logic        gpio;
    logic        en;
    logic        clr;
    logic        exp_gpio;
    logic        exp_rise;
    logic        exp_fall;
    logic [15:0] exp_glitch;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        clr;
  logic        gpio_in;
  logic        gpio_out;
  logic        rise;
  logic        fall;
  logic [15:0] glitch_cnt;

  int total = 0;
  int bad   = 0;

  vec_t vecs[$];

  always #5 clk = ~clk;

  gpio_debounce #(
    .SyncStages(SyncStages),
    .StableCnt (StableCnt)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .clr_i       (clr),
    .gpio_i      (gpio_in),
    .gpio_o      (gpio_out),
    .rise_o      (rise),
    .fall_o      (fall),
    .glitch_cnt_o(glitch_cnt)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic g, input logic r, input logic f,
                           input logic [15:0] gl);
    chk({tag, ".gpio"}, {15'd0, gpio_out}, {15'd0, g});
    chk({tag, ".rise"}, {15'd0, rise}, {15'd0, r});
    chk({tag, ".fall"}, {15'd0, fall}, {15'd0, f});
    chk({tag, ".glitch"}, glitch_cnt, gl);
    chk({tag, ".excl"}, {15'd0, rise & fall}, 16'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic g, input logic e, input logic c, input logic eg,
                              input logic er, input logic ef, input logic [15:0] egl);
    vec_t v;
    v.gpio = g; v.en = e; v.clr = c;
    v.exp_gpio = eg; v.exp_rise = er; v.exp_fall = ef; v.exp_glitch = egl;
    vecs.push_back(v);
  endfunction

  // Glitch of 3 high edges then 4 low; optional clear on the rejecting edge.
  task automatic glitch(input logic clr_at_reject);
    for (int off = 0; off < 7; off++) begin
      gpio_in = (off < 3);
      clr     = clr_at_reject && (off == 5);
      step();
    end
    clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Clean rise: s high from E1, sampled E2..E5, gpio_o rises after E5.
    for (int i = 0; i < 5; i++) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0);
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    // Release: fall after SyncStages+StableCnt = 6 edges.
    for (int i = 0; i < 5; i++) add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    // Five 3-edge glitches; each is rejected on block offset 5.
    for (int n = 1; n <= 5; n++) begin
      for (int off = 0; off < 7; off++) begin
        add(off < 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, (off >= 5) ? 16'(n) : 16'(n - 1));
      end
    end

    rst = 1'b1; en = 1'b1; clr = 1'b0; gpio_in = 1'b0;
    #12;
    check_out("reset", 1'b0, 1'b0, 1'b0, 16'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      gpio_in = vecs[i].gpio;
      en      = vecs[i].en;
      clr     = vecs[i].clr;
      step();
      check_out($sformatf("vec%0d", i), vecs[i].exp_gpio, vecs[i].exp_rise,
                vecs[i].exp_fall, vecs[i].exp_glitch);
    end

    // Enable dropped in CHECK_HI at cnt=2, then re-raised with s=1.
    gpio_in = 1'b1;
    repeat (4) step();
    check_out("en_pre", 1'b0, 1'b0, 1'b0, 16'd5);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_out("en_off", 1'b0, 1'b0, 1'b0, 16'd5);
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("en_restart", 1'b0, 1'b0, 1'b0, 16'd5);
    end
    step();
    check_out("en_accept", 1'b1, 1'b1, 1'b0, 16'd5);
    step();
    check_out("en_after", 1'b1, 1'b0, 1'b0, 16'd5);

    gpio_in = 1'b0;
    repeat (5) step();
    check_out("rel_wait", 1'b1, 1'b0, 1'b0, 16'd5);
    step();
    check_out("rel_fall", 1'b0, 1'b0, 1'b1, 16'd5);

    // Saturation from a preloaded count.
    dut.glitch_cnt_q = 16'hFFFE;
    glitch(1'b0);
    check_out("sat1", 1'b0, 1'b0, 1'b0, 16'hFFFF);
    glitch(1'b0);
    glitch(1'b0);
    check_out("sat3", 1'b0, 1'b0, 1'b0, 16'hFFFF);

    // Clear coincident with a rejection, then counting resumes.
    glitch(1'b1);
    check_out("clr_rej", 1'b0, 1'b0, 1'b0, 16'd0);
    glitch(1'b0);
    check_out("after_clr", 1'b0, 1'b0, 1'b0, 16'd1);

    // Asynchronous reset at cnt=3 abandons the check.
    gpio_in = 1'b1;
    repeat (5) step();
    check_out("rst_pre", 1'b0, 1'b0, 1'b0, 16'd1);
    #2;
    rst = 1'b1;
    #1;
    check_out("rst_async", 1'b0, 1'b0, 1'b0, 16'd0);
    step();
    check_out("rst_hold", 1'b0, 1'b0, 1'b0, 16'd0);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_out("rst_relat", 1'b0, 1'b0, 1'b0, 16'd0);
    end
    step();
    check_out("rst_rise", 1'b1, 1'b1, 1'b0, 16'd0);
    step();
    check_out("rst_end", 1'b1, 1'b0, 1'b0, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_debounce.md
# gpio_debounce

Input conditioning stage for a raw, asynchronous GPIO pin: synchronizes the pin into `clk_i`, rejects pulses shorter than a programmable stable time, and produces a clean level plus single-cycle edge strobes. Sits directly upstream of the GPIO counter/event logic, whose `gpio_i` is driven from this block's `gpio_o`. It also keeps a saturating count of rejected glitches for software diagnostics.

## Interface
- `SyncStages`, default 2: synchronizer flop depth; legal values are ≥ 2.
- `StableCnt`, default 16: number of consecutive sampling edges a new level must hold before it is accepted; legal values are ≥ 1.
- `clk_i` input, 1 bit: single clock.
- `rst_i` input, 1 bit: reset, asynchronous, active-high.
- `en_i` input, 1 bit: filter enable.
- `clr_i` input, 1 bit: synchronous clear of `glitch_cnt_o`.
- `gpio_i` input, 1 bit: raw pin, asynchronous to `clk_i`.
- `gpio_o` output, 1 bit: filtered level, registered.
- `rise_o` output, 1 bit: one-cycle pulse when `gpio_o` goes 0→1, registered.
- `fall_o` output, 1 bit: one-cycle pulse when `gpio_o` goes 1→0, registered.
- `glitch_cnt_o` output, 16 bits: saturating count of rejected transitions.

## Operation
- `s` is the output of the synchronizer chain; only `s` feeds the FSM.
- FSM states:
  - `STABLE_LO`: `gpio_o` is 0.
  - `CHECK_HI`
  - `STABLE_HI`: `gpio_o` is 1.
  - `CHECK_LO`
- Counter `cnt` has width `$clog2(StableCnt+1)`.
- In `STABLE_LO`, when `en_i`=1 and `s`=1:
  - If `StableCnt`==1, go directly to `STABLE_HI` and set `gpio_o`=1 and `rise_o`=1.
  - Otherwise go to `CHECK_HI` with `cnt`←1.
- In `CHECK_HI`:
  - `s`=1 and `cnt`==`StableCnt`−1: go to `STABLE_HI`, `gpio_o`←1, `rise_o`←1, `cnt`←0.
  - `s`=1 otherwise: `cnt`←`cnt`+1.
  - `s`=0: return to `STABLE_LO`, `cnt`←0, `glitch_cnt_o` increments.
- `STABLE_HI` and `CHECK_LO` mirror the above with polarity inverted; acceptance produces `fall_o`.
- `en_i`=0:
  - Any `CHECK_*` state returns to its stable state with `cnt`←0.
  - No glitch is counted and no strobe is emitted.
  - The stable states do not leave; `gpio_o` holds its value.
  - The synchronizer keeps running.
- `glitch_cnt_o`:
  - Saturates at 0xFFFF.
  - `clr_i` has priority over an increment in the same cycle; the result is 0.
- The counter is unreachable-safe: an illegal state encoding returns to `STABLE_LO` with `cnt`←0.

## Timing
- Reset (asynchronous, immediate on `rst_i`=1):
  - Synchronizer flops 0, state `STABLE_LO`, `cnt` 0.
  - `gpio_o`=0, `rise_o`=0, `fall_o`=0, `glitch_cnt_o`=0.
- Reset asserted mid-check abandons the check. No strobe is emitted.
- Latency:
  - Let E0 be the edge at which the first synchronizer flop captures a new level.
  - `gpio_o` changes at edge E0+`SyncStages`+`StableCnt`−1.
  - Defaults: 17 edges after E0.
  - `SyncStages`=2, `StableCnt`=4: edges E2..E5 sample `s`, and `gpio_o` rises after E5.
- `rise_o`/`fall_o` are high for exactly the one cycle following the edge on which `gpio_o` changes. They are coincident with the new `gpio_o` value.
- `rise_o` and `fall_o` are never high together.
- Minimum spacing between strobes is `StableCnt` cycles.
- A pulse on `s` lasting fewer than `StableCnt` sampling edges never reaches `gpio_o` and increments `glitch_cnt_o` by exactly 1.
- `glitch_cnt_o` updates one edge after the rejecting sample.

## Structure
- Package `gpio_debounce_pkg` holds:
  - The state typedef `debounce_state_e` (2-bit enum).
  - Constant `GlitchCntWidth` = 16.
- Sub-module `gpio_sync`:
  - Parameterized by `SyncStages`.
  - Plain flop chain with asynchronous active-high reset to 0.
  - Reusable for other pins.
- The remainder of the block (FSM, counter, strobes, glitch counter) lives in the `gpio_debounce` top module.

## Test plan
- Clean edge: `SyncStages`=2, `StableCnt`=4. Hold `gpio_i`=1 from E0. Required: `gpio_o` rises after E5, `rise_o` is high for one cycle, `glitch_cnt_o`=0.
- Glitch: `gpio_i` high for 3 edges, then low, with `StableCnt`=4. Required: `gpio_o` stays 0, no strobe, `glitch_cnt_o`=1. Repeat 5 times; `glitch_cnt_o`=5.
- Release: from `gpio_o`=1, drive `gpio_i`=0 and hold. Required: `fall_o` one cycle, `gpio_o`=0 after `SyncStages`+`StableCnt` edges.
- Enable: drop `en_i` during `CHECK_HI` at `cnt`=2. Required: return to `STABLE_LO`, no glitch count. Re-raise `en_i` with `s`=1. Required: full `StableCnt` restart.
- Saturation and clear:
  - Preload 0xFFFE, then inject 3 glitches. Required: `glitch_cnt_o`=0xFFFF.
  - Assert `clr_i` in the same cycle as a glitch rejection. Required: 0.
- Reset mid-check: assert `rst_i` asynchronously at `cnt`=3 while `gpio_i`=1. Required: all outputs 0 immediately. After release, the full latency of `SyncStages`+`StableCnt` edges applies again.
